// File: rtl/store_queue_pkg.sv
// Shared types and width helpers for the buffered store queue.
package store_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } sq_state_t;

    function automatic int off_bits(input int bus_bytes);
        return $clog2(bus_bytes);
    endfunction

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered-storage FIFO, head visible combinationally; push ignored when full.
// Pointers and count reset asynchronously; storage is not reset.
module sync_fifo
    import store_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_dat,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_dat,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_BITS = ptr_bits(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (PTR_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_BITS+1)'(1);
                2'b01:   count <= count - (PTR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/store_queue.sv
// Queues byte-enabled stores and drains each as one or two aligned bus beats; 2-cycle accept-to-beat latency.
// CPU stalls only when the queue is full; beats are held stable while mem_ready is low.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int BUS_BYTES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     write_ready,
    input  logic                     write_req,
    input  logic [ADDR_WIDTH-1:0]    write_addr,
    input  logic [8*BUS_BYTES-1:0]   write_data,
    input  logic [BUS_BYTES-1:0]     write_byte_enable,
    input  logic                     mem_ready,
    output logic                     mem_write_req,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [8*BUS_BYTES-1:0]   mem_write_data,
    output logic [BUS_BYTES-1:0]     mem_byte_enable,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     idle
);
    localparam int OFF_BITS = off_bits(BUS_BYTES);
    localparam int BW       = 8 * BUS_BYTES;
    localparam int AW       = ADDR_WIDTH - OFF_BITS;
    localparam int EW       = AW + 2*BW + 2*BUS_BYTES;

    logic [OFF_BITS-1:0]    off;
    logic [2*BW-1:0]        in_word;
    logic [2*BUS_BYTES-1:0] in_be;
    logic [EW-1:0]          in_entry;
    logic [EW-1:0]          head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    assign off      = write_addr[OFF_BITS-1:0];
    assign in_word  = {{BW{1'b0}}, write_data} << {off, 3'b000};
    assign in_be    = {{BUS_BYTES{1'b0}}, write_byte_enable} << off;
    assign in_entry = {write_addr[ADDR_WIDTH-1:OFF_BITS], in_word, in_be};

    assign write_ready = !fifo_full;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (write_req && write_ready),
        .push_dat (in_entry),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

    logic [AW-1:0]          head_addr;
    logic [AW-1:0]          head_hi_addr;
    logic [2*BW-1:0]        head_word;
    logic [2*BUS_BYTES-1:0] head_be;

    assign head_addr    = head[EW-1 -: AW];
    assign head_word    = head[2*BUS_BYTES +: 2*BW];
    assign head_be      = head[0 +: 2*BUS_BYTES];
    assign head_hi_addr = head_addr + AW'(1);

    sq_state_t              state, state_n;
    logic                   req_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [BW-1:0]          data_n;
    logic [BUS_BYTES-1:0]   be_n;
    // Upper half of the current entry, parked until the low beat completes.
    logic [AW-1:0]          hi_addr, hi_addr_n;
    logic [BW-1:0]          hi_data, hi_data_n;
    logic [BUS_BYTES-1:0]   hi_be, hi_be_n;
    logic                   hs;
    logic                   load;

    assign hs   = mem_write_req && mem_ready;
    assign idle = (state == IDLE) && fifo_empty;

    always_comb begin
        state_n   = state;
        req_n     = mem_write_req;
        addr_n    = mem_addr;
        data_n    = mem_write_data;
        be_n      = mem_byte_enable;
        hi_addr_n = hi_addr;
        hi_data_n = hi_data;
        hi_be_n   = hi_be;
        pop       = 1'b0;
        load      = 1'b0;

        case (state)
            IDLE: load = 1'b1;
            LOW: begin
                if (hs) begin
                    if (hi_be != '0) begin
                        state_n = HIGH;
                        addr_n  = {hi_addr, {OFF_BITS{1'b0}}};
                        data_n  = hi_data;
                        be_n    = hi_be;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            HIGH:    load = hs;
            default: state_n = IDLE;
        endcase

        if (load) begin
            req_n   = 1'b0;
            state_n = IDLE;
            if (!fifo_empty) begin
                pop       = 1'b1;
                hi_addr_n = head_hi_addr;
                hi_data_n = head_word[2*BW-1:BW];
                hi_be_n   = head_be[2*BUS_BYTES-1:BUS_BYTES];
                if (head_be[BUS_BYTES-1:0] != '0) begin
                    req_n   = 1'b1;
                    state_n = LOW;
                    addr_n  = {head_addr, {OFF_BITS{1'b0}}};
                    data_n  = head_word[BW-1:0];
                    be_n    = head_be[BUS_BYTES-1:0];
                end else if (head_be[2*BUS_BYTES-1:BUS_BYTES] != '0) begin
                    req_n   = 1'b1;
                    state_n = HIGH;
                    addr_n  = {head_hi_addr, {OFF_BITS{1'b0}}};
                    data_n  = head_word[2*BW-1:BW];
                    be_n    = head_be[2*BUS_BYTES-1:BUS_BYTES];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            mem_write_req   <= 1'b0;
            mem_addr        <= '0;
            mem_write_data  <= '0;
            mem_byte_enable <= '0;
            hi_addr         <= '0;
            hi_data         <= '0;
            hi_be           <= '0;
        end else begin
            state           <= state_n;
            mem_write_req   <= req_n;
            mem_addr        <= addr_n;
            mem_write_data  <= data_n;
            mem_byte_enable <= be_n;
            hi_addr         <= hi_addr_n;
            hi_data         <= hi_data_n;
            hi_be           <= hi_be_n;
        end
    end

endmodule
